// File: rtl/cs_pkg.sv
// rtl/cs_pkg.sv - shared types and constants for the CS frame scheduler
package cs_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RUN,
    DRAIN
  } cs_state_t;

  localparam int CS_DW  = 8;
  localparam int CS_YW  = 10;
  localparam int CS_WIN = 9;

endpackage

// File: rtl/cs_out_fifo.sv
// rtl/cs_out_fifo.sv - synchronous result FIFO with occupancy count and flush
module cs_out_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 10,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          s_tvalid,
  input  logic [W-1:0]  s_tdata,
  output logic          m_tvalid,
  input  logic          m_tready,
  output logic [W-1:0]  m_tdata,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign m_tvalid = (cnt != '0);
  assign m_tdata  = m_tvalid ? mem[rd_ptr] : '0;
  assign pop      = m_tvalid && m_tready;
  assign count    = cnt;

  // Pointer and occupancy tracking; a flush discards everything including same-cycle traffic
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (s_tvalid) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)      rd_ptr <= ptr_inc(rd_ptr);
      case ({s_tvalid, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage array; contents are don't-care while the count says empty
  always_ff @(posedge clk) begin
    if (s_tvalid && !clr) mem[wr_ptr] <= s_tdata;
  end

endmodule

// File: rtl/cs_frame_sched.sv
// rtl/cs_frame_sched.sv - frame sequencer between a sample source and the CS window core
module cs_frame_sched
  import cs_pkg::*;
#(
  parameter int DW       = CS_DW,
  parameter int YW       = CS_YW,
  parameter int WIN      = CS_WIN,
  parameter int LAT      = 1,
  parameter int OF_DEPTH = 4,
  parameter int FLW      = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           abort,
  input  logic [FLW-1:0] frame_len,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [DW-1:0]  in_data,
  output logic [DW-1:0]  core_x,
  output logic           core_shift,
  output logic           core_clr,
  input  logic [YW-1:0]  core_y,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [YW-1:0]  out_y,
  output logic           busy,
  output logic           done,
  output logic           err_short
);

  localparam int             CW     = $clog2(OF_DEPTH + 1);
  localparam logic [FLW-1:0] WIN_L  = FLW'(WIN);
  localparam logic [FLW-1:0] WIN_M1 = FLW'(WIN - 1);
  localparam logic [CW:0]    CRED   = (CW + 1)'(OF_DEPTH);

  cs_state_t      state_q, state_d;
  logic [FLW-1:0] len_q;
  logic [FLW-1:0] acc_cnt;
  logic [FLW-1:0] acc_inc;
  logic [DW-1:0]  x_hold;
  logic [LAT-1:0] tag_q;
  logic [CW:0]    inflight;
  logic [CW-1:0]  fifo_cnt;
  logic           accept;
  logic           tag_in;
  logic           load;
  logic           clr_d;
  logic           done_d;
  logic           err_d;
  logic           abort_eff;

  assign acc_inc    = acc_cnt + 1'b1;
  assign abort_eff  = abort && (state_q != IDLE);
  assign busy       = (state_q != IDLE);
  assign accept     = in_valid && in_ready;
  assign core_shift = accept;
  assign core_x     = accept ? in_data : x_hold;

  // Results already requested from the core but not yet landed in the FIFO
  always_comb begin
    inflight = '0;
    for (int i = 0; i < LAT; i++) inflight = inflight + (CW + 1)'(tag_q[i]);
  end

  // Input readiness: free during warm-up, credit-limited once results are being produced
  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      FILL:    in_ready = !abort;
      RUN:     in_ready = !abort && (({1'b0, fifo_cnt} + inflight) < CRED);
      default: in_ready = 1'b0;
    endcase
  end

  // Next-state and pulse requests; abort overrides everything else
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    tag_in  = 1'b0;
    clr_d   = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          if (frame_len < WIN_L) begin
            err_d = 1'b1;
          end else begin
            load    = 1'b1;
            clr_d   = 1'b1;
            state_d = FILL;
          end
        end
      end
      FILL: begin
        if (accept && acc_cnt == WIN_M1) begin
          tag_in  = 1'b1;
          state_d = (acc_inc == len_q) ? DRAIN : RUN;
        end
      end
      RUN: begin
        if (accept) begin
          tag_in = 1'b1;
          if (acc_inc == len_q) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (inflight == '0 && fifo_cnt == '0) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort_eff) begin
      state_d = IDLE;
      tag_in  = 1'b0;
      clr_d   = 1'b1;
      done_d  = 1'b0;
    end
  end

  // State register and registered one-cycle pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      core_clr  <= 1'b0;
      done      <= 1'b0;
      err_short <= 1'b0;
    end else begin
      state_q   <= state_d;
      core_clr  <= clr_d;
      done      <= done_d;
      err_short <= err_d;
    end
  end

  // Frame length latch, accepted-sample counter and held core sample
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_q   <= '0;
      acc_cnt <= '0;
      x_hold  <= '0;
    end else begin
      if (load) begin
        len_q   <= frame_len;
        acc_cnt <= '0;
      end else if (accept) begin
        acc_cnt <= acc_inc;
      end
      if (accept) x_hold <= in_data;
    end
  end

  // Tag pipe mirrors core latency so core_y is captured exactly when it is valid
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_q <= '0;
    end else if (abort_eff) begin
      tag_q <= '0;
    end else begin
      tag_q[0] <= tag_in;
      for (int i = 1; i < LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  cs_out_fifo #(
    .DEPTH (OF_DEPTH),
    .W     (YW),
    .CW    (CW)
  ) u_out_fifo (
    .clk      (clk),
    .rst_n    (reset),
    .clr      (abort_eff),
    .s_tvalid (tag_q[LAT-1]),
    .s_tdata  (core_y),
    .m_tvalid (out_valid),
    .m_tready (out_ready),
    .m_tdata  (out_y),
    .count    (fifo_cnt)
  );

endmodule

// File: tb/tb_cs_frame_sched.sv
// tb/tb_cs_frame_sched.sv - randomized self-checking bench for cs_frame_sched
module tb_cs_frame_sched;
  import cs_pkg::*;

  localparam int DW  = 8;
  localparam int YW  = 10;
  localparam int WIN = 9;
  localparam int OFD = 4;
  localparam int FLW = 16;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           start = 1'b0;
  logic           abort = 1'b0;
  logic [FLW-1:0] frame_len = '0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [DW-1:0]  in_data = '0;
  logic [DW-1:0]  core_x;
  logic           core_shift;
  logic           core_clr;
  logic [YW-1:0]  core_y;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [YW-1:0]  out_y;
  logic           busy;
  logic           done;
  logic           err_short;
  logic [24:0]    outs;

  assign outs = {in_ready, core_x, core_shift, core_clr, out_valid, out_y, busy, done, err_short};

  cs_frame_sched dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .frame_len  (frame_len),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .core_x     (core_x),
    .core_shift (core_shift),
    .core_clr   (core_clr),
    .core_y     (core_y),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_y      (out_y),
    .busy       (busy),
    .done       (done),
    .err_short  (err_short)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Stand-in CS core: window sum of the last WIN samples, one cycle after shift
  logic [DW-1:0] cwin [WIN];
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      core_y <= '0;
      for (int i = 0; i < WIN; i++) cwin[i] <= '0;
    end else if (core_shift) begin
      int s;
      s = int'(core_x);
      for (int i = 0; i < WIN - 1; i++) s += (core_clr ? 0 : int'(cwin[i]));
      for (int i = WIN - 1; i > 0; i--) cwin[i] <= core_clr ? '0 : cwin[i-1];
      cwin[0] <= core_x;
      core_y  <= YW'(s);
    end else if (core_clr) begin
      for (int i = 0; i < WIN; i++) cwin[i] <= '0;
    end
  end

  // Reference model and monitors: expected results come from the accepted sample stream
  int            acc_n, res_n, shift_n, done_n, err_n, clr_n;
  bit            busy_seen, rdy_seen;
  int            hist[$];
  logic [YW-1:0] expq[$];
  logic          prev_v = 1'b0;
  logic          prev_r = 1'b1;
  logic [YW-1:0] prev_y = '0;

  always @(negedge clk) begin
    if (!reset) begin
      prev_v = 1'b0;
      prev_r = 1'b1;
    end else begin
      check("shift_eq_accept", core_shift, in_valid & in_ready);
      if (in_valid && in_ready) begin
        int s;
        check("core_x", core_x, in_data);
        acc_n++;
        hist.push_back(int'(in_data));
        if (hist.size() >= WIN) begin
          s = 0;
          for (int i = hist.size() - WIN; i < hist.size(); i++) s += hist[i];
          expq.push_back(YW'(s % 1024));
        end
      end
      if (core_shift) shift_n++;
      if (prev_v && !prev_r) check("hold_stable", {out_valid, out_y}, {1'b1, prev_y});
      if (out_valid && out_ready) begin
        if (expq.size() == 0) check("extra_result", 1, 0);
        else check("out_y", out_y, expq.pop_front());
        res_n++;
      end
      done_n += int'(done);
      err_n  += int'(err_short);
      clr_n  += int'(core_clr);
      busy_seen |= busy;
      rdy_seen  |= in_ready;
      prev_v = out_valid;
      prev_r = out_ready;
      prev_y = out_y;
    end
  end

  task automatic start_frame(input int len);
    hist.delete();
    expq.delete();
    acc_n = 0; res_n = 0; shift_n = 0; done_n = 0; err_n = 0; clr_n = 0;
    busy_seen = 0; rdy_seen = 0;
    @(posedge clk); #1;
    start = 1'b1;
    frame_len = FLW'(len);
    @(posedge clk); #1;
    start = 1'b0;
    if (len >= WIN) begin
      check("clr_after_start", core_clr, 1);
      check("busy_after_start", busy, 1);
    end else begin
      check("err_after_start", err_short, 1);
    end
  endtask

  task automatic drive_until(input int stop_at, input int pv, input int pr, input bit seq, input bit poke);
    int cyc = 0;
    while (acc_n < stop_at && cyc < 4000) begin
      @(posedge clk); #1;
      cyc++;
      if (acc_n >= stop_at) break;
      in_valid  = ($urandom_range(99) < pv);
      in_data   = seq ? DW'(acc_n + 1) : DW'($urandom);
      out_ready = ($urandom_range(99) < pr);
      if (poke) begin
        start     = 1'($urandom_range(1));
        frame_len = FLW'(3);
      end
    end
    in_valid = 1'b0;
    start    = 1'b0;
    check("feed_count", acc_n, stop_at);
  endtask

  task automatic wait_done(input int pr);
    int cyc = 0;
    while (done_n == 0 && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
      out_ready = ($urandom_range(99) < pr);
    end
    check("done_seen", done_n, 1);
  endtask

  task automatic frame_checks(input int len);
    repeat (3) @(posedge clk);
    #1;
    check("result_count", res_n, len - WIN + 1);
    check("shift_count", shift_n, len);
    check("done_once", done_n, 1);
    check("no_err_short", err_n, 0);
    check("leftover", expq.size(), 0);
    check("idle_after", busy, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", outs, 0);
    reset = 1'b1;

    // minimal frame, sequential samples 1..9
    start_frame(9);
    drive_until(9, 100, 100, 1'b1, 1'b0);
    wait_done(100);
    frame_checks(9);

    // short frame rejected
    start_frame(5);
    repeat (4) @(posedge clk);
    #1;
    check("err_pulse_count", err_n, 1);
    check("short_busy", busy_seen, 0);
    check("short_in_ready", rdy_seen, 0);
    check("short_no_clr", clr_n, 0);

    // back-pressure: credit stops input after OF_DEPTH results in flight
    start_frame(20);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    repeat (40) begin
      @(posedge clk); #1;
      in_data = DW'($urandom);
    end
    in_valid = 1'b0;
    check("credit_accepts", acc_n, WIN - 1 + OFD);
    check("credit_in_ready", in_ready, 0);
    check("credit_out_valid", out_valid, 1);
    drive_until(20, 100, 100, 1'b0, 1'b0);
    wait_done(100);
    frame_checks(20);

    // abort in RUN after 12 samples
    start_frame(30);
    drive_until(12, 100, 100, 1'b0, 1'b0);
    abort = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("abort_in_ready", in_ready, 0);
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_idle", busy, 0);
    check("abort_clr", core_clr, 1);
    check("abort_out_valid", out_valid, 0);
    expq.delete();
    repeat (10) @(posedge clk);
    #1;
    check("abort_no_done", done_n, 0);
    check("abort_still_empty", out_valid, 0);

    // asynchronous reset mid-FILL, then a clean frame
    start_frame(30);
    drive_until(5, 100, 100, 1'b1, 1'b0);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    check("async_reset_outputs", outs, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    check("reset_no_done", done_n, 0);
    check("reset_no_err", err_n, 0);
    start_frame(9);
    drive_until(9, 100, 100, 1'b1, 1'b0);
    wait_done(100);
    frame_checks(9);

    // random frames with random valid/ready and stray start requests while busy
    for (int f = 0; f < 6; f++) begin
      int len;
      len = int'($urandom_range(40, 9));
      start_frame(len);
      drive_until(len, 60, 50, 1'b0, 1'b1);
      wait_done(50);
      frame_checks(len);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
